// File: rtl/alu_seq_param.sv
// Registered WIDTH-bit ALU with 16 opcodes, carry-flag chaining and an iterative
// shift-add multiplier, wrapped in valid/ready handshakes on both sides.
module alu_seq_param #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow
);

  localparam int SHW = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_NOT  = 4'h5;
  localparam logic [3:0] OP_SHL  = 4'h6;
  localparam logic [3:0] OP_SHR  = 4'h7;
  localparam logic [3:0] OP_ADC  = 4'h8;
  localparam logic [3:0] OP_SBB  = 4'h9;
  localparam logic [3:0] OP_SRA  = 4'hA;
  localparam logic [3:0] OP_ROL  = 4'hB;
  localparam logic [3:0] OP_ROR  = 4'hC;
  localparam logic [3:0] OP_MUL  = 4'hD;
  localparam logic [3:0] OP_CMP  = 4'hE;
  localparam logic [3:0] OP_ZERO = 4'hF;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DONE
  } state_t;

  state_t state;
  logic   cf;
  logic   accept;

  // Multiplier datapath: multiplicand shifts left, multiplier shifts right.
  logic [2*WIDTH-1:0] mul_acc;
  logic [2*WIDTH-1:0] mul_mcand;
  logic [WIDTH-1:0]   mul_mplier;
  logic [SHW-1:0]     mul_cnt;
  logic [2*WIDTH-1:0] mul_sum;
  logic               mul_hi_nz;

  // Single-cycle ALU evaluated on the live operands; captured only on accept.
  logic [WIDTH:0]     add_ext;
  logic [WIDTH:0]     sub_ext;
  logic [SHW-1:0]     shamt;
  logic [2*WIDTH-1:0] rot_l;
  logic [2*WIDTH-1:0] rot_r;
  logic               ovf_add;
  logic               ovf_sub;
  logic [WIDTH-1:0]   alu_result;
  logic               alu_carry;
  logic               alu_zero;
  logic               alu_overflow;

  assign in_ready = (state == S_IDLE) | ((state == S_DONE) & out_ready);
  assign accept   = in_valid & in_ready;

  assign mul_sum   = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
  assign mul_hi_nz = |mul_sum[2*WIDTH-1:WIDTH];

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    alu_result   = '0;
    alu_carry    = 1'b0;
    alu_overflow = 1'b0;

    add_ext = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (opcode == OP_ADC) & cf};
    sub_ext = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, (opcode == OP_SBB) & cf};
    ovf_add = (~a[MSB] & ~b[MSB] &  add_ext[MSB]) | (a[MSB] &  b[MSB] & ~add_ext[MSB]);
    ovf_sub = (~a[MSB] &  b[MSB] &  sub_ext[MSB]) | (a[MSB] & ~b[MSB] & ~sub_ext[MSB]);

    shamt = b[SHW-1:0];
    rot_l = {a, a} << shamt;
    rot_r = {a, a} >> shamt;

    case (opcode)
      OP_ADD, OP_ADC: begin
        alu_result   = add_ext[WIDTH-1:0];
        alu_carry    = add_ext[WIDTH];
        alu_overflow = ovf_add;
      end
      OP_SUB, OP_SBB: begin
        alu_result   = sub_ext[WIDTH-1:0];
        alu_carry    = sub_ext[WIDTH];
        alu_overflow = ovf_sub;
      end
      OP_AND:  alu_result = a & b;
      OP_OR:   alu_result = a | b;
      OP_XOR:  alu_result = a ^ b;
      OP_NOT:  alu_result = ~a;
      OP_SHL:  alu_result = {a[WIDTH-2:0], 1'b0};
      OP_SHR:  alu_result = {1'b0, a[WIDTH-1:1]};
      OP_SRA:  alu_result = $signed(a) >>> shamt;
      OP_ROL:  alu_result = rot_l[2*WIDTH-1:WIDTH];
      OP_ROR:  alu_result = rot_r[WIDTH-1:0];
      OP_CMP: begin
        alu_result = a;
        alu_carry  = sub_ext[WIDTH];
      end
      OP_MUL, OP_ZERO: alu_result = '0;
      default:         alu_result = '0;
    endcase

    // Compare reports the flags of the subtraction while passing a through.
    alu_zero = (opcode == OP_CMP) ? (sub_ext[WIDTH-1:0] == '0) : (alu_result == '0);
  end

  // NOTE: all state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      out_valid  <= 1'b0;
      result     <= '0;
      carry      <= 1'b0;
      zero       <= 1'b0;
      overflow   <= 1'b0;
      cf         <= 1'b0;
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_cnt    <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            if (opcode == OP_MUL) begin
              state      <= S_MUL;
              out_valid  <= 1'b0;
              mul_acc    <= '0;
              mul_mcand  <= {{WIDTH{1'b0}}, a};
              mul_mplier <= b;
              mul_cnt    <= '0;
            end else begin
              state     <= S_DONE;
              out_valid <= 1'b1;
              result    <= alu_result;
              carry     <= alu_carry;
              zero      <= alu_zero;
              overflow  <= alu_overflow;
              cf        <= alu_carry;
            end
          end else if ((state == S_DONE) && out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
          end
        end

        S_MUL: begin
          mul_acc    <= mul_sum;
          mul_mcand  <= mul_mcand << 1;
          mul_mplier <= mul_mplier >> 1;
          mul_cnt    <= mul_cnt + SHW'(1);
          // Last of WIDTH steps: the product is complete in mul_sum this cycle.
          if (mul_cnt == SHW'(WIDTH - 1)) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            result    <= mul_sum[WIDTH-1:0];
            carry     <= mul_hi_nz;
            zero      <= (mul_sum[WIDTH-1:0] == '0);
            overflow  <= 1'b0;
            cf        <= mul_hi_nz;
          end
        end

        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_param.sv
// Scoreboard bench for alu_seq_param (WIDTH=8): stimulus pushes hand-computed
// results into a queue, an independent monitor pops on every output handshake.
module tb_alu_seq_param;

  localparam int WIDTH = 8;

  localparam logic [3:0] ADD = 4'h0, SUB = 4'h1, AND_ = 4'h2, OR_ = 4'h3;
  localparam logic [3:0] XOR_ = 4'h4, NOT_ = 4'h5, SHL = 4'h6, SHR = 4'h7;
  localparam logic [3:0] ADC = 4'h8, SBB = 4'h9, SRA = 4'hA, ROL = 4'hB;
  localparam logic [3:0] ROR = 4'hC, MUL = 4'hD, CMP = 4'hE, ZRO = 4'hF;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       opcode;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             overflow;

  typedef struct packed {
    logic [7:0] tag;
    logic [7:0] result;
    logic       carry;
    logic       zero;
    logic       overflow;
  } exp_t;

  typedef struct packed {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] r;
    logic       c;
    logic       z;
    logic       v;
  } vec_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   waits;

  alu_seq_param #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .opcode   (opcode),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .carry    (carry),
    .zero     (zero),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [7:0] tag, input logic [3:0] op, input logic [7:0] aa,
                      input logic [7:0] bb, input logic [7:0] er, input logic ec,
                      input logic ez, input logic ev, input bit push, output int nw);
    exp_t e;
    in_valid = 1'b1;
    opcode   = op;
    a        = aa;
    b        = bb;
    nw       = 0;
    @(negedge clk);
    while (!in_ready && nw < 100) begin
      nw++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check($sformatf("accept_timeout_op%0d", tag), in_ready, 1);
      in_valid = 1'b0;
      return;
    end
    if (push) begin
      e = '{tag: tag, result: er, carry: ec, zero: ez, overflow: ev};
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic do_op(input logic [7:0] tag, input logic [3:0] op, input logic [7:0] aa,
                       input logic [7:0] bb, input logic [7:0] er, input logic ec,
                       input logic ez, input logic ev);
    int nw;
    send(tag, op, aa, bb, er, ec, ez, ev, 1'b1, nw);
    waits = nw;
  endtask

  // Monitor: one pop per completed output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_output", sb_q.size(), 1);
        end else begin
          e = sb_q.pop_front();
          check($sformatf("op%0d_result", e.tag), result, e.result);
          check($sformatf("op%0d_carry", e.tag), carry, e.carry);
          check($sformatf("op%0d_zero", e.tag), zero, e.zero);
          check($sformatf("op%0d_overflow", e.tag), overflow, e.overflow);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs [0:17];
    vecs = '{
      '{ADD,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0},
      '{ADC,  8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0},
      '{SUB,  8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0},
      '{SBB,  8'h05, 8'h02, 8'h02, 1'b0, 1'b0, 1'b0},
      '{SUB,  8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1},
      '{AND_, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0},
      '{OR_,  8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b0},
      '{XOR_, 8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0, 1'b0},
      '{NOT_, 8'h5A, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b0},
      '{SHL,  8'h81, 8'h00, 8'h02, 1'b0, 1'b0, 1'b0},
      '{SHR,  8'h81, 8'h00, 8'h40, 1'b0, 1'b0, 1'b0},
      '{ROR,  8'h81, 8'h01, 8'hC0, 1'b0, 1'b0, 1'b0},
      '{SRA,  8'h80, 8'h03, 8'hF0, 1'b0, 1'b0, 1'b0},
      '{ROL,  8'h81, 8'h09, 8'h03, 1'b0, 1'b0, 1'b0},
      '{CMP,  8'h05, 8'h05, 8'h05, 1'b0, 1'b1, 1'b0},
      '{CMP,  8'h03, 8'h05, 8'h03, 1'b1, 1'b0, 1'b0},
      '{ADC,  8'h01, 8'h01, 8'h03, 1'b0, 1'b0, 1'b0},
      '{ZRO,  8'h12, 8'h34, 8'h00, 1'b0, 1'b1, 1'b0}
    };

    rst       = 1'b1;
    in_valid  = 1'b0;
    opcode    = 4'h0;
    a         = '0;
    b         = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_result", result, 0);
    check("reset_carry", carry, 0);
    check("reset_zero", zero, 0);
    check("reset_overflow", overflow, 0);
    check("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    do_op(8'd1, ADD, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("add_latency_out_valid", out_valid, 1);
    @(posedge clk);
    #1;

    // Back-to-back table; carry flag chains from one row into the next.
    for (int i = 0; i < 18; i++) begin
      do_op(8'(10 + i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].r, vecs[i].c, vecs[i].z, vecs[i].v);
      if (i > 0) check($sformatf("b2b_wait_op%0d", 10 + i), waits, 0);
    end

    // Multiply latency; operands are scrambled after accept.
    do_op(8'd40, MUL, 8'h10, 8'h11, 8'h10, 1'b1, 1'b0, 1'b0);
    a      = 8'h00;
    b      = 8'h00;
    opcode = AND_;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("mul_busy_out_valid_c%0d", i), out_valid, 0);
      check($sformatf("mul_busy_in_ready_c%0d", i), in_ready, 0);
    end
    @(negedge clk);
    check("mul_latency_out_valid", out_valid, 1);
    @(posedge clk);
    #1;

    do_op(8'd41, MUL, 8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b0);
    do_op(8'd42, ADC, 8'h00, 8'h00, 8'h01, 1'b0, 1'b0, 1'b0);
    do_op(8'd43, MUL, 8'h00, 8'h37, 8'h00, 1'b0, 1'b1, 1'b0);

    // Backpressure: hold the ADD result while the next op waits on in_valid.
    do_op(8'd50, ADD, 8'h01, 8'h02, 8'h03, 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    opcode    = XOR_;
    a         = 8'h0F;
    b         = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("stall_out_valid_c%0d", i), out_valid, 1);
      check($sformatf("stall_in_ready_c%0d", i), in_ready, 0);
      check($sformatf("stall_result_c%0d", i), result, 8'h03);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    do_op(8'd51, XOR_, 8'h0F, 8'hFF, 8'hF0, 1'b0, 1'b0, 1'b0);
    check("release_wait", waits, 0);
    do_op(8'd52, SUB, 8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b0);
    check("tput_wait_52", waits, 0);
    do_op(8'd53, ADD, 8'h40, 8'h40, 8'h80, 1'b0, 1'b0, 1'b1);
    check("tput_wait_53", waits, 0);
    do_op(8'd54, AND_, 8'hFF, 8'hAA, 8'hAA, 1'b0, 1'b0, 1'b0);
    check("tput_wait_54", waits, 0);

    // Reset three cycles into a multiply: op discarded, cf cleared.
    do_op(8'd60, SUB, 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0);
    send(8'd61, MUL, 8'h10, 8'h11, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, waits);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midmul_rst_out_valid", out_valid, 0);
    check("midmul_rst_in_ready", in_ready, 1);
    check("midmul_rst_result", result, 0);
    check("midmul_rst_carry", carry, 0);
    @(posedge clk);
    #1;
    do_op(8'd62, ADC, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);

    repeat (12) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
